// File: rtl/sp_ram_pkg.sv
// Shared types for the single-port SRAM initiator: FSM states, response record and widths.
package sp_ram_pkg;

  typedef enum logic [0:0] {
    StInitClear,
    StRun
  } state_e;

  localparam int unsigned RSP_DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH       = RSP_DATA_WIDTH / 8;

  typedef struct packed {
    logic [RSP_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } rsp_t;

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Response FIFO with occupancy output; pointers wrap modulo DEPTH (need not be a power of two).
module sp_ram_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push_i & ((cnt_q != Full) | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/sp_ram_initiator.sv
// Core-bus to single-port SRAM initiator with range/write-protect checks and credit-based
// response buffering. Optional power-up clear of the RAM: SP_RAM_INITIATOR_INIT_CLEAR_EN.
module sp_ram_initiator
  import sp_ram_pkg::*;
#(
  parameter int unsigned RAM_SIZE       = 32768,
  parameter int unsigned ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int unsigned BUS_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = RSP_DATA_WIDTH,
  parameter int unsigned RSP_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [BUS_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_we_i,
  input  logic [DATA_WIDTH/8-1:0]   req_be_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic                      wp_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      ram_en_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic                      ram_bypass_en_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned CntW = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned RspW = DATA_WIDTH + 1;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(RSP_DEPTH);

  logic            run;
  logic            accept, req_ok, in_range, pop;
  logic [CntW-1:0] fifo_cnt;
  logic [CntW:0]   pending;
  logic            fifo_empty;
  logic [RspW-1:0] push_data, head_data;
  logic            inflight_q, inflight_d;
  logic            infl_rd_q, infl_rd_d;
  logic            infl_err_q, infl_err_d;

`ifdef SP_RAM_INITIATOR_INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_SIZE - BeW);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= StInitClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      StInitClear: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(BeW);
        if (clr_addr_q == LastAddr) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  assign run = (state_q == StRun);
`else
  assign run = 1'b1;
`endif

  // Any bit at or above ADDR_WIDTH means the address is past the end of the RAM.
  assign in_range = ~|req_addr_i[BUS_ADDR_WIDTH-1:ADDR_WIDTH];
  assign req_ok   = in_range & ~(req_we_i & wp_i);
  assign pop      = rsp_valid_o & rsp_ready_i;

  // Credit: buffered plus in-flight responses, less the one leaving now, must leave room.
  assign pending     = {1'b0, fifo_cnt} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
  assign req_ready_o = ~rst_i & run & (pending < DepthLim);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    ram_en_o        = 1'b0;
    ram_addr_o      = '0;
    ram_wdata_o     = '0;
    ram_we_o        = 1'b0;
    ram_be_o        = '0;
    ram_bypass_en_o = 1'b0;
`ifdef SP_RAM_INITIATOR_INIT_CLEAR_EN
    if (!rst_i && state_q == StInitClear) begin
      ram_en_o   = 1'b1;
      ram_addr_o = clr_addr_q;
      ram_we_o   = 1'b1;
      ram_be_o   = '1;
    end else
`endif
    if (accept && req_ok) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = req_addr_i[ADDR_WIDTH-1:0];
      ram_wdata_o = req_wdata_i;
      ram_we_o    = req_we_i;
      ram_be_o    = req_be_i;
    end
  end

  always_comb begin
    inflight_d = accept;
    infl_rd_d  = accept & ~req_we_i;
    infl_err_d = accept & ~req_ok;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      infl_rd_q  <= 1'b0;
      infl_err_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      infl_rd_q  <= infl_rd_d;
      infl_err_q <= infl_err_d;
    end
  end

  // RAM read data is only meaningful the cycle after a successful read strobe.
  always_comb begin
    push_data = {infl_err_q, {DATA_WIDTH{1'b0}}};
    if (infl_rd_q && !infl_err_q) push_data[DATA_WIDTH-1:0] = ram_rdata_i;
  end

  sp_ram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RspW)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head_data),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  assign rsp_valid_o = ~fifo_empty;
  assign rsp_rdata_o = fifo_empty ? '0 : head_data[DATA_WIDTH-1:0];
  assign rsp_err_o   = ~fifo_empty & head_data[DATA_WIDTH];

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Randomised bench for sp_ram_initiator with an SRAM model and a request-level reference model.
module tb_sp_ram_initiator;

  localparam int unsigned RamSize = 32768;
  localparam int unsigned Words   = RamSize / 4;
`ifdef SP_RAM_INITIATOR_INIT_CLEAR_EN
  localparam int ClearCycles = 8192;
`else
  localparam int ClearCycles = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_we_i = 1'b0;
  logic [3:0]  req_be_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        wp_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        ram_en_o;
  logic [14:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic        ram_bypass_en_o;
  logic [31:0] ram_rdata_i = '0;

  always #5 clk = ~clk;

  sp_ram_initiator dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_we_i        (req_we_i),
    .req_be_i        (req_be_i),
    .req_wdata_i     (req_wdata_i),
    .wp_i            (wp_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .ram_en_o        (ram_en_o),
    .ram_addr_o      (ram_addr_o),
    .ram_wdata_o     (ram_wdata_o),
    .ram_we_o        (ram_we_o),
    .ram_be_o        (ram_be_o),
    .ram_bypass_en_o (ram_bypass_en_o),
    .ram_rdata_i     (ram_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM model: random power-up contents, write with byte mask, 1-cycle read latency.
  logic [31:0] mem [Words];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    logic [31:0] w;
    if (!mem_init) begin
      for (int i = 0; i < int'(Words); i++) mem[i] <= $urandom;
      mem_init <= 1'b1;
    end else if (ram_en_o) begin
      if (!ram_we_o) begin
        ram_rdata_i <= mem[ram_addr_o[14:2]];
      end else if (!ram_bypass_en_o) begin
        w = mem[ram_addr_o[14:2]];
        for (int b = 0; b < 4; b++) if (ram_be_o[b]) w[8*b +: 8] = ram_wdata_o[8*b +: 8];
        mem[ram_addr_o[14:2]] <= w;
      end
    end
  end

  // Reference model: memory image, queue of expected responses, outstanding count.
  logic [31:0] ref_mem [Words];
  bit          ref_init = 1'b0;
  logic [32:0] exp_q [$];
  int          out_cnt = 0;
  int          max_out = 0;
  int          clear_left = 0;
  bit          hold_q = 1'b0;
  logic [32:0] hold_val = '0;

  always @(negedge clk) begin
    logic        acc, pop, ok, clearing;
    int          wi;
    logic [31:0] w;
    logic [32:0] e;
    if (!ref_init) begin
      for (int i = 0; i < int'(Words); i++) ref_mem[i] = mem[i];
      ref_init = 1'b1;
    end
    acc = req_valid_i && req_ready_o;
    pop = rsp_valid_o && rsp_ready_i;
    if (rst_i) begin
      exp_q.delete();
      out_cnt    = 0;
      hold_q     = 1'b0;
      clear_left = ClearCycles;
      if (ClearCycles > 0) for (int i = 0; i < int'(Words); i++) ref_mem[i] = '0;
      check_eq("ready_in_reset", 64'(req_ready_o), 64'(0));
    end else begin
      clearing = (clear_left > 0);
      check_eq("credit_ready", 64'(req_ready_o), 64'(!clearing && (out_cnt - int'(pop)) < 2));
      if (hold_q)
        check_eq("rsp_hold", 64'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 64'({1'b1, hold_val}));
      if (pop) begin
        check_eq("rsp_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rsp", 64'({rsp_err_o, rsp_rdata_o}), 64'(e));
        end
        out_cnt--;
      end
      if (acc) begin
        ok = (req_addr_i < RamSize) && !(req_we_i && wp_i);
        wi = int'(req_addr_i[14:2]);
        if (ok) begin
          check_eq("ram_port",
                   64'({ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, ram_bypass_en_o}),
                   64'({1'b1, req_addr_i[14:0], req_we_i, req_be_i, req_wdata_i, 1'b0}));
          if (req_we_i) begin
            w = ref_mem[wi];
            for (int b = 0; b < 4; b++) if (req_be_i[b]) w[8*b +: 8] = req_wdata_i[8*b +: 8];
            ref_mem[wi] = w;
            exp_q.push_back({1'b0, 32'h0});
          end else begin
            exp_q.push_back({1'b0, ref_mem[wi]});
          end
        end else begin
          check_eq("ram_en_err", 64'(ram_en_o), 64'(0));
          exp_q.push_back({1'b1, 32'h0});
        end
        out_cnt++;
        if (out_cnt > max_out) max_out = out_cnt;
      end else if (clearing) begin
        check_eq("clear_port",
                 64'({ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, ram_bypass_en_o}),
                 64'({1'b1, 15'((ClearCycles - clear_left) * 4), 1'b1, 4'hF, 32'h0, 1'b0}));
        clear_left--;
      end else begin
        check_eq("ram_idle", 64'({ram_en_o, ram_we_o, ram_be_o}), 64'(0));
      end
      hold_q   = rsp_valid_o && !rsp_ready_i;
      hold_val = {rsp_err_o, rsp_rdata_o};
    end
  end

  task automatic do_reset();
    int n = 0;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 64'(0));
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    while (!req_ready_o && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check_eq("init_cycles", 64'(n), 64'(ClearCycles));
    @(posedge clk);
    #1;
  endtask

  // Presents one request (caller is just past a rising edge); returns just past the accepting edge.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic wp);
    int n = 0;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_be_i    = be;
    req_wdata_i = wdata;
    wp_i        = wp;
    @(negedge clk);
    while (!req_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check_eq("accept_timeout", 64'(req_ready_o), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Single request on an idle pipeline with fixed-latency check; returns the T+2 response.
  task automatic single(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic wp,
                        output logic [31:0] rdata, output logic err);
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b1;
    issue(addr, we, be, wdata, wp);
    req_valid_i = 1'b0;
    wp_i        = 1'b0;
    @(negedge clk);
    check_eq("lat_t1_valid", 64'(rsp_valid_o), 64'(0));
    @(negedge clk);
    check_eq("lat_t2_valid", 64'(rsp_valid_o), 64'(1));
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
  endtask

  logic [31:0] rd, old40, addr;
  logic        er;
  bit          done;
  int          k;

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();

    single(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, rd, er);
    check_eq("wr_err", 64'(er), 64'(0));
    check_eq("wr_rdata", 64'(rd), 64'(0));
    single(32'h10, 1'b0, 4'h0, 32'h0, 1'b0, rd, er);
    check_eq("rd_deadbeef", 64'({er, rd}), 64'({1'b0, 32'hDEADBEEF}));

    single(32'h20, 1'b1, 4'hF, 32'h11223344, 1'b0, rd, er);
    single(32'h20, 1'b1, 4'b0010, 32'h0000AB00, 1'b0, rd, er);
    single(32'h20, 1'b0, 4'h0, 32'h0, 1'b0, rd, er);
    check_eq("rd_partial", 64'({er, rd}), 64'({1'b0, 32'h1122AB44}));

    single(32'h8000, 1'b0, 4'h0, 32'h0, 1'b0, rd, er);
    check_eq("oor_rsp", 64'({er, rd}), 64'({1'b1, 32'h0}));

    old40 = ref_mem[16];
    single(32'h40, 1'b1, 4'hF, 32'h55, 1'b1, rd, er);
    check_eq("wp_rsp", 64'({er, rd}), 64'({1'b1, 32'h0}));
    single(32'h40, 1'b0, 4'h0, 32'h0, 1'b0, rd, er);
    check_eq("wp_old", 64'({er, rd}), 64'({1'b0, old40}));

    // Eight back-to-back reads with the consumer stalled for five cycles mid-burst.
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(32'h100 + 32'(i * 4), 1'b0, 4'h0, 32'h0, 1'b0);
        req_valid_i = 1'b0;
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        rsp_ready_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rsp_ready_i = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check_eq("burst_drain", 64'(exp_q.size()), 64'(0));

    // Reset with two responses buffered.
    rsp_ready_i = 1'b0;
    issue(32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
    issue(32'h20, 1'b0, 4'h0, 32'h0, 1'b0);
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("buffered_valid", 64'(rsp_valid_o), 64'(1));
    do_reset();
    rsp_ready_i = 1'b1;
`ifdef SP_RAM_INITIATOR_INIT_CLEAR_EN
    single(32'h10, 1'b0, 4'h0, 32'h0, 1'b0, rd, er);
    check_eq("clear_read", 64'({er, rd}), 64'(0));
`endif

    // Randomised traffic with a random consumer.
    done = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          k = int'($urandom % 16);
          if (k == 0)      addr = 32'h8000 + ($urandom % 64) * 4;
          else if (k == 1) addr = $urandom & 32'hFFFF_FFFC;
          else             addr = ($urandom % 32) * 4;
          issue(addr, 1'($urandom), 4'($urandom), $urandom, ($urandom % 8) == 0);
          req_valid_i = 1'b0;
          wp_i        = 1'b0;
          k = int'($urandom % 3);
          repeat (k) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rsp_ready_i = ($urandom % 10) < 7;
        end
        rsp_ready_i = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check_eq("final_drain", 64'(exp_q.size()), 64'(0));
    check_eq("max_outstanding", 64'(max_out), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
